// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with double-buffered display data.
// Outputs are registered from next-state values so they line up with cnt/idx/disp.
`timescale 1ns/1ps

module seven_seg_scanner #(
  parameter int CLK_DIV          = 50000,
  parameter int BLANK_CYCLES     = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_data,
  input  logic [3:0]  i_dp,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_blank_lz,
  output logic [3:0]  o_nibble,
  output logic [3:0]  o_anode,
  output logic        o_dp,
  output logic        o_frame_done
);

  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [3:0]     ANODE_OFF = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;

  localparam phase_t PHASE_START = (BLANK_CYCLES > 0) ? PH_BLANK : PH_DRIVE;

  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    idx, idx_next;
  phase_t        phase, phase_next;

  logic [15:0]   disp_data, disp_data_next;
  logic [3:0]    disp_dp, disp_dp_next;
  logic [15:0]   pend_data;
  logic [3:0]    pend_dp;
  logic          pend_full;

  logic          slot_end;
  logic          frame_end;
  logic          load;

  logic [3:0]    digit_zero;
  logic [3:0]    lz_mask;
  logic          suppress;
  logic [3:0]    onehot;
  logic [3:0]    anode_next;
  logic [3:0]    nibble_next;
  logic          dp_next;

  assign o_ready   = ~pend_full;
  assign load      = i_valid & ~pend_full;
  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end & (idx == 2'd3);

  assign cnt_next = slot_end ? '0 : cnt + 1'b1;
  assign idx_next = slot_end ? idx + 2'd1 : idx;

  // The display only swaps on a frame boundary, and only if something was waiting before it.
  assign disp_data_next = (frame_end & pend_full) ? pend_data : disp_data;
  assign disp_dp_next   = (frame_end & pend_full) ? pend_dp   : disp_dp;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      idx   <= 2'd0;
      phase <= PHASE_START;
    end else begin
      cnt   <= cnt_next;
      idx   <= idx_next;
      phase <= phase_next;
    end
  end

  always_comb begin
    phase_next = phase;
    case (phase)
      PH_BLANK: if (cnt_next == BLANK_END) phase_next = PH_DRIVE;
      PH_DRIVE: if (slot_end && (BLANK_CYCLES > 0)) phase_next = PH_BLANK;
      default:  phase_next = PHASE_START;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      disp_data <= 16'h0000;
      disp_dp   <= 4'h0;
      pend_data <= 16'h0000;
      pend_dp   <= 4'h0;
      pend_full <= 1'b0;
    end else begin
      disp_data <= disp_data_next;
      disp_dp   <= disp_dp_next;
      if (load) begin
        pend_data <= i_data;
        pend_dp   <= i_dp;
        pend_full <= 1'b1;
      end else if (frame_end) begin
        pend_full <= 1'b0;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      digit_zero[k] = (disp_data_next[4*k +: 4] == 4'h0);
    end
    lz_mask[3] = digit_zero[3];
    lz_mask[2] = digit_zero[3] & digit_zero[2];
    lz_mask[1] = digit_zero[3] & digit_zero[2] & digit_zero[1];
    lz_mask[0] = 1'b0;
  end

  always_comb begin
    suppress    = i_blank_lz & lz_mask[idx_next];
    onehot      = 4'b0001 << idx_next;
    nibble_next = disp_data_next[{idx_next, 2'b00} +: 4];
    anode_next  = ANODE_OFF;
    dp_next     = 1'b0;
    if (phase_next == PH_DRIVE) begin
      dp_next = disp_dp_next[idx_next];
      if (!suppress) begin
        anode_next = ANODE_ACTIVE_LOW ? ~onehot : onehot;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_nibble     <= 4'h0;
      o_anode      <= ANODE_OFF;
      o_dp         <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_nibble     <= nibble_next;
      o_anode      <= anode_next;
      o_dp         <= dp_next;
      o_frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (CLK_DIV=8, BLANK_CYCLES=2, active-low anodes).
// A time-indexed reference model queues the expected outputs for each edge.
`timescale 1ns/1ps

module tb_seven_seg_scanner;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;
  localparam logic [10:0] RST_EXP = {1'b1, 1'b0, 1'b0, 4'h0, 4'hF};

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_data;
  logic [3:0]  i_dp;
  logic        i_valid;
  logic        o_ready;
  logic        i_blank_lz;
  logic [3:0]  o_nibble;
  logic [3:0]  o_anode;
  logic        o_dp;
  logic        o_frame_done;

  int checks;
  int errors;

  int          mt;
  logic [15:0] mdisp, mpend;
  logic [3:0]  mdispdp, mpenddp;
  logic        mfull;
  logic [10:0] exp_q[$];

  seven_seg_scanner #(
    .CLK_DIV(CLK_DIV),
    .BLANK_CYCLES(BLANK),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_data(i_data),
    .i_dp(i_dp),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_blank_lz(i_blank_lz),
    .o_nibble(o_nibble),
    .o_anode(o_anode),
    .o_dp(o_dp),
    .o_frame_done(o_frame_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    mt      = 0;
    mdisp   = 16'h0000;
    mdispdp = 4'h0;
    mpend   = 16'h0000;
    mpenddp = 4'h0;
    mfull   = 1'b0;
    exp_q.delete();
  endtask

  // Position in the scan is derived purely from the number of edges since reset.
  task automatic model_edge(input logic v, input logic [15:0] d, input logic [3:0] p,
                            input logic blz, output logic [10:0] e);
    int c0, i0, c1, i1;
    logic bnd, ready_before, blank;
    logic [3:0] oh, an, nib;
    c0 = mt % CLK_DIV;
    i0 = (mt / CLK_DIV) % 4;
    bnd = (c0 == CLK_DIV - 1) && (i0 == 3);
    ready_before = !mfull;
    if (bnd && mfull) begin
      mdisp   = mpend;
      mdispdp = mpenddp;
      mfull   = 1'b0;
    end
    if (v && ready_before) begin
      mpend   = d;
      mpenddp = p;
      mfull   = 1'b1;
    end
    mt++;
    c1 = mt % CLK_DIV;
    i1 = (mt / CLK_DIV) % 4;
    blank = (c1 < BLANK) || (blz && (i1 != 0) && ((mdisp >> (4 * i1)) == 16'h0));
    oh  = 4'b0001 << i1;
    an  = blank ? 4'hF : ~oh;
    nib = 4'((mdisp >> (4 * i1)) & 16'h000F);
    e = {!mfull, bnd, (c1 >= BLANK) && mdispdp[i1], nib, an};
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [15:0] d,
                               input logic [3:0] p, input logic blz);
    logic [10:0] e;
    logic [10:0] o;
    @(negedge i_clk);
    i_valid    = v;
    i_data     = d;
    i_dp       = p;
    i_blank_lz = blz;
    model_edge(v, d, p, blz, e);
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    o = {o_ready, o_frame_done, o_dp, o_nibble, o_anode};
    checkOutput(tag, {21'h0, o}, {21'h0, exp_q.pop_front()});
  endtask

  task automatic run_idle(input string tag, input int n, input logic blz);
    for (int k = 0; k < n; k++) begin
      applyStimulus(tag, 1'b0, 16'h0000, 4'h0, blz);
    end
  endtask

  task automatic wait_frame_pos(input string tag, input int pos, input logic blz);
    for (int k = 0; k < FRAME && (mt % FRAME) != pos; k++) begin
      applyStimulus(tag, 1'b0, 16'h0000, 4'h0, blz);
    end
  endtask

  function automatic logic [10:0] outputs_now();
    return {o_ready, o_frame_done, o_dp, o_nibble, o_anode};
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    i_rst      = 1'b1;
    i_valid    = 1'b0;
    i_data     = 16'h0000;
    i_dp       = 4'h0;
    i_blank_lz = 1'b0;
    model_reset();

    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_hold", {21'h0, outputs_now()}, {21'h0, RST_EXP});
    i_rst = 1'b0;

    run_idle("idle_scan", 70, 1'b0);

    applyStimulus("load_mid", 1'b1, 16'h12AB, 4'b0100, 1'b0);
    applyStimulus("load_ignored", 1'b1, 16'hFFFF, 4'hF, 1'b0);
    run_idle("show_12ab", 80, 1'b0);

    wait_frame_pos("seek_wrap", FRAME - 1, 1'b0);
    applyStimulus("wrap_load", 1'b1, 16'h3456, 4'b0001, 1'b0);
    run_idle("after_wrap", 70, 1'b0);

    applyStimulus("load_0050", 1'b1, 16'h0050, 4'b0000, 1'b1);
    run_idle("lz_0050", 80, 1'b1);
    applyStimulus("load_0000", 1'b1, 16'h0000, 4'b0010, 1'b1);
    run_idle("lz_0000", 80, 1'b1);
    run_idle("lz_off", 40, 1'b0);

    wait_frame_pos("seek_mid", 10, 1'b0);
    applyStimulus("load_9876", 1'b1, 16'h9876, 4'b1010, 1'b0);
    run_idle("pend_full", 3, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("reset_async", {21'h0, outputs_now()}, {21'h0, RST_EXP});
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    checkOutput("reset_hold2", {21'h0, outputs_now()}, {21'h0, RST_EXP});
    model_reset();
    i_rst = 1'b0;
    run_idle("post_reset", 70, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named i_clk and i_rst.
REQ-002 Parameter CLK_DIV, default 50000: clock cycles per digit slot; legal values are >= 2.
REQ-003 Parameter BLANK_CYCLES, default 4: cycles at the start of each slot with all anodes off (anti-ghosting); legal values are 0 .. CLK_DIV-1.
REQ-004 Parameter ANODE_ACTIVE_LOW, default 1: when 1, an anode is driven 0 to enable its digit.
REQ-005 i_clk  input  1  system clock.
REQ-006 i_rst  input  1  asynchronous active-high reset.
REQ-007 i_data  input  16  four hex digits; bits [3:0] are digit 0, the rightmost and least significant.
REQ-008 i_dp  input  4  decimal-point request, one bit per digit; the bit index equals the digit index.
REQ-009 i_valid  input  1  load request for i_data and i_dp.
REQ-010 o_ready  output  1  the pending buffer is empty and a load will be accepted.
REQ-011 i_blank_lz  input  1  when 1, leading zeros are suppressed.
REQ-012 o_nibble  output  4  hex nibble for the current digit; feeds the downstream hex-to-seven-segment decoder.
REQ-013 o_anode  output  4  digit enables, one-hot active (polarity per ANODE_ACTIVE_LOW).
REQ-014 o_dp  output  1  decimal point for the current digit, active high.
REQ-015 o_frame_done  output  1  one-cycle pulse when digit 3 completes.

Function
REQ-016 The block SHALL keep a slot counter cnt that runs 0..CLK_DIV-1 and wraps to 0; digit index idx (2 bits) SHALL increment, wrapping 3->0, on every cnt wrap.
REQ-017 Per slot the block SHALL have two states:
  - BLANK while cnt < BLANK_CYCLES: all anodes inactive.
  - DRIVE otherwise: only anode[idx] active.
  - BLANK_CYCLES=0 means DRIVE for the whole slot.
REQ-018 o_nibble SHALL equal disp_data[4*idx+3 : 4*idx], and o_dp SHALL equal disp_dp[idx] in DRIVE and 0 in BLANK.
REQ-019 o_nibble, o_anode, o_dp and o_frame_done SHALL be registered and SHALL change only on the clock edge where cnt/idx/disp change, with zero cycles of lag relative to that state.
REQ-020 Load handshake: a load SHALL occur when i_valid=1 and o_ready=1 at a rising edge.
  - The load copies i_data/i_dp into the pending buffer.
  - o_ready SHALL be 0 from the next cycle.
  - i_valid while o_ready=0 SHALL be ignored (no overwrite).
REQ-021 Frame boundary: this is the edge where idx wraps 3->0.
  - If pending was full before that edge, the pending contents SHALL move into disp_data/disp_dp on that edge.
  - o_ready SHALL be 1 from the following cycle.
REQ-022 If a load and a frame boundary fall on the same edge with pending empty:
  - the new value SHALL enter pending only;
  - it SHALL be displayed from the next frame boundary;
  - the display SHALL never change mid-frame.
REQ-023 Leading-zero blanking: when i_blank_lz=1, digit idx (for idx 1..3) SHALL show all anodes inactive during its slot if disp_data digit idx and all higher digits are 0.
  - Digit 0 SHALL never be blanked.
  - i_blank_lz SHALL take effect immediately, with no latching.
REQ-024 o_frame_done SHALL be 1 for exactly the one cycle following the 3->0 wrap edge, and 0 otherwise.

Reset
REQ-025 While i_rst=1 the block SHALL hold all of the following, asynchronously:
  - cnt=0, idx=0, disp_data=16'h0000, disp_dp=4'h0;
  - pending empty, o_ready=1;
  - o_anode all inactive (4'hF when ANODE_ACTIVE_LOW=1);
  - o_nibble=0, o_dp=0, o_frame_done=0.
REQ-026 On release, scanning SHALL begin at digit 0, slot start (BLANK phase if BLANK_CYCLES>0).
REQ-027 Reset asserted mid-frame or with pending full SHALL discard the pending data and SHALL NOT update the display.

Verification (CLK_DIV=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1)
REQ-028 Reset release, no load -> o_anode sequence 1111 (2 cycles), 1110 (6), 1111 (2), 1101 (6), ... with o_nibble=0 throughout and o_frame_done pulsing every 32 cycles.
REQ-029 Load i_data=16'h12AB, i_dp=4'b0100 mid-frame -> o_ready falls; the display is unchanged until the boundary; the next frame shows nibbles B,A,2,1 for digits 0..3 with o_dp=1 only in digit 2 DRIVE; o_ready=1 on the cycle after the boundary.
REQ-030 With pending full, assert i_valid with 16'hFFFF -> ignored; the earlier pending value is the one displayed.
REQ-031 Load on the exact 3->0 wrap edge with pending empty -> the old value is shown for one full frame, then the new value.
REQ-032 i_blank_lz=1 with disp_data=16'h0050 -> digits 3 and 2 are never enabled; digit 1 shows 5; digit 0 shows 0 and is enabled. With disp_data=16'h0000, only digit 0 is enabled.
REQ-033 Assert i_rst asynchronously mid-slot with pending full -> outputs take reset values immediately; after release the display shows 0 and o_ready=1.
